// File: rtl/si_bus_fifo_pkg.sv
// ============================================================================
// Module : si_bus_fifo_pkg
// Brief  : Register map and status bit layout shared by the bus FIFO slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package si_bus_fifo_pkg;

    localparam int DATA_W  = 32;
    localparam int LEVEL_W = 17;

    localparam logic [3:0] REG_VERSION = 4'd0;
    localparam logic [3:0] REG_STATUS  = 4'd1;
    localparam logic [3:0] REG_LEVEL_L = 4'd2;
    localparam logic [3:0] REG_LEVEL_H = 4'd3;
    localparam logic [3:0] REG_LOST_0  = 4'd4;
    localparam logic [3:0] REG_LOST_1  = 4'd5;
    localparam logic [3:0] REG_LOST_2  = 4'd6;
    localparam logic [3:0] REG_LOST_3  = 4'd7;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVERFLOW = 2;

    function automatic logic [15:0] sat_level(input logic [LEVEL_W-1:0] lvl);
        return lvl[LEVEL_W-1] ? 16'hFFFF : lvl[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/si_bus_fifo_mem.sv
// ============================================================================
// Module : si_bus_fifo_mem
// Brief  : DEPTH x 32 simple dual-port RAM, synchronous write, registered read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module si_bus_fifo_mem
    import si_bus_fifo_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read-before-write on a same-address collision: a full FIFO pushing and
    // popping together must return the old head word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/si_bus_fifo.sv
// ============================================================================
// Module : si_bus_fifo
// Brief  : Bus slave draining a producer word stream through a FIFO, with a
//          byte-wide status/level/lost register window.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module si_bus_fifo
    import si_bus_fifo_pkg::*;
#(
    parameter logic [31:0] BASEADDR      = 32'h0000_8000,
    parameter logic [31:0] HIGHADDR      = 32'h0000_800F,
    parameter logic [31:0] BASEADDR_DATA = 32'h8000_0000,
    parameter logic [31:0] HIGHADDR_DATA = 32'h8000_FFFF,
    parameter int          DEPTH         = 1024,
    parameter logic [7:0]  VERSION       = 8'd1
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST_N,
    input  logic [31:0]       BUS_ADD,
    inout  wire  [31:0]       BUS_DATA,
    input  logic              BUS_RD,
    input  logic              BUS_WR,
    input  logic              FIFO_WRITE,
    input  logic [DATA_W-1:0] FIFO_DATA,
    output logic              FIFO_FULL,
    output logic              FIFO_EMPTY
);

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] C_DEPTH = LEVEL_W'(DEPTH);

    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic [31:0]        r_lost, r_snap_lost;
    logic [15:0]        r_snap_level;
    logic               r_ovf, r_full, r_empty;
    logic               r_out_en, r_out_sel_data, r_out_valid;
    logic [7:0]         r_out_byte;

    logic               w_reg_hit, w_data_hit, w_reg_rd, w_soft_rst;
    logic [3:0]         w_reg_off;
    logic               w_do_pop, w_do_push, w_drop, w_is_full;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [15:0]        w_level_sat;
    logic [7:0]         w_status, w_reg_byte;
    logic [DATA_W-1:0]  w_ram_q, w_out_word;

    assign w_reg_hit  = (BUS_ADD >= BASEADDR) && (BUS_ADD <= HIGHADDR);
    assign w_data_hit = (BUS_ADD >= BASEADDR_DATA) && (BUS_ADD <= HIGHADDR_DATA);
    assign w_reg_off  = 4'(BUS_ADD - BASEADDR);
    assign w_reg_rd   = BUS_RD & w_reg_hit;
    assign w_soft_rst = BUS_WR & w_reg_hit & (w_reg_off == REG_VERSION);

    // A pop on an empty FIFO is a no-op; a push into a full FIFO only lands
    // when a pop frees the slot in the same cycle.
    assign w_is_full  = (r_level == C_DEPTH);
    assign w_do_pop   = BUS_RD & w_data_hit & (r_level != '0);
    assign w_do_push  = FIFO_WRITE & ~w_soft_rst & (~w_is_full | w_do_pop);
    assign w_drop     = FIFO_WRITE & ~w_soft_rst & w_is_full & ~w_do_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_do_push && !w_do_pop)      w_level_nxt = r_level + LEVEL_W'(1);
        else if (!w_do_push && w_do_pop) w_level_nxt = r_level - LEVEL_W'(1);
    end

    assign w_level_sat = sat_level(r_level);

    always_comb begin
        w_status                = '0;
        w_status[STAT_EMPTY]    = r_empty;
        w_status[STAT_FULL]     = r_full;
        w_status[STAT_OVERFLOW] = r_ovf;
    end

    always_comb begin
        w_reg_byte = 8'h00;
        case (w_reg_off)
            REG_VERSION: w_reg_byte = VERSION;
            REG_STATUS:  w_reg_byte = w_status;
            REG_LEVEL_L: w_reg_byte = w_level_sat[7:0];
            REG_LEVEL_H: w_reg_byte = r_snap_level[15:8];
            REG_LOST_0:  w_reg_byte = r_lost[7:0];
            REG_LOST_1:  w_reg_byte = r_snap_lost[15:8];
            REG_LOST_2:  w_reg_byte = r_snap_lost[23:16];
            REG_LOST_3:  w_reg_byte = r_snap_lost[31:24];
            default:     w_reg_byte = 8'h00;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_lost         <= '0;
            r_snap_lost    <= '0;
            r_snap_level   <= '0;
            r_ovf          <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_out_en       <= 1'b0;
            r_out_sel_data <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_byte     <= '0;
        end else begin
            r_out_en       <= BUS_RD & (w_reg_hit | w_data_hit);
            r_out_sel_data <= w_data_hit;
            r_out_valid    <= w_do_pop;
            if (w_reg_rd) r_out_byte <= w_reg_byte;

            if (w_soft_rst) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_level      <= '0;
                r_lost       <= '0;
                r_snap_lost  <= '0;
                r_snap_level <= '0;
                r_ovf        <= 1'b0;
                r_full       <= 1'b0;
                r_empty      <= 1'b1;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_level <= w_level_nxt;
                r_empty <= (w_level_nxt == '0);
                r_full  <= (w_level_nxt == C_DEPTH);
                if (w_drop) begin
                    r_ovf <= 1'b1;
                    if (r_lost != 32'hFFFF_FFFF) r_lost <= r_lost + 32'd1;
                end
                if (w_reg_rd && w_reg_off == REG_LEVEL_L) r_snap_level <= w_level_sat;
                if (w_reg_rd && w_reg_off == REG_LOST_0)  r_snap_lost  <= r_lost;
            end
        end
    end

    si_bus_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (BUS_CLK),
        .i_we    (w_do_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (FIFO_DATA),
        .i_re    (w_do_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    assign w_out_word = r_out_sel_data ? (r_out_valid ? w_ram_q : '0)
                                       : {24'h0, r_out_byte};
    assign BUS_DATA   = r_out_en ? w_out_word : 32'hz;
    assign FIFO_FULL  = r_full;
    assign FIFO_EMPTY = r_empty;

endmodule

`default_nettype wire
